// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback request channels, the register-file write port
// and the status outputs of regfile_write_arbiter.
//   a_valid/a_addr/a_data -> a_ready : requester A (ALU result)
//   b_valid/b_addr/b_data -> b_ready : requester B (memory load)
//   we3/wa3/wd3                      : registered register-file write port
//   pending                          : per-register "write still in flight"
//   busy                             : any queued entry or write on the port
// master = requester/controller side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    logic                  a_valid;
    logic [AW-1:0]         a_addr;
    logic [DW-1:0]         a_data;
    logic                  a_ready;
    logic                  b_valid;
    logic [AW-1:0]         b_addr;
    logic [DW-1:0]         b_data;
    logic                  b_ready;
    logic                  we3;
    logic [AW-1:0]         wa3;
    logic [DW-1:0]         wd3;
    logic [(1<<AW)-1:0]    pending;
    logic                  busy;

    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        input  we3, wa3, wd3, pending, busy
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        output we3, wa3, wd3, pending, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between requester A (ALU) and
// requester B (load). Each requester has a DEPTH-entry FIFO; a round-robin
// arbiter drains the heads onto a registered write port (we3/wa3/wd3).
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous, active-low
//   bus   : slave side of regfile_write_arbiter_if (requests, write port,
//           pending scoreboard, busy)
//
// Arbiter state (last_grant):
//   state   | meaning
//   GRANT_A | A was granted last; B wins the next tie
//   GRANT_B | B was granted last (reset value); A wins the next tie
module regfile_write_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int          PW   = $clog2(DEPTH);
    localparam int          NREG = 1 << AW;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_t;

    grant_t            last_grant, last_grant_nxt;

    logic [AW-1:0]     addr_a [DEPTH];
    logic [DW-1:0]     data_a [DEPTH];
    logic [DEPTH-1:0]  vld_a;
    logic [PW-1:0]     wr_ptr_a, rd_ptr_a;
    logic [PW:0]       count_a;

    logic [AW-1:0]     addr_b [DEPTH];
    logic [DW-1:0]     data_b [DEPTH];
    logic [DEPTH-1:0]  vld_b;
    logic [PW-1:0]     wr_ptr_b, rd_ptr_b;
    logic [PW:0]       count_b;

    logic              push_a, push_b, pop_a, pop_b;
    logic              nonempty_a, nonempty_b;
    logic [AW-1:0]     head_addr;
    logic [DW-1:0]     head_data;

    logic              we3_q;
    logic [AW-1:0]     wa3_q;
    logic [DW-1:0]     wd3_q;
    logic [NREG-1:0]   pend;

    // Ready depends only on the registered count: a same-cycle pop never
    // frees room for a push.
    assign bus.a_ready = reset && (count_a != FULL);
    assign bus.b_ready = reset && (count_b != FULL);
    assign push_a      = bus.a_valid && bus.a_ready;
    assign push_b      = bus.b_valid && bus.b_ready;
    assign nonempty_a  = (count_a != '0);
    assign nonempty_b  = (count_b != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= GRANT_B;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        last_grant_nxt = last_grant;
        pop_a          = 1'b0;
        pop_b          = 1'b0;
        if (nonempty_a && (!nonempty_b || last_grant == GRANT_B)) begin
            pop_a          = 1'b1;
            last_grant_nxt = GRANT_A;
        end else if (nonempty_b) begin
            pop_b          = 1'b1;
            last_grant_nxt = GRANT_B;
        end
    end

    assign head_addr = pop_a ? addr_a[rd_ptr_a] : addr_b[rd_ptr_b];
    assign head_data = pop_a ? data_a[rd_ptr_a] : data_b[rd_ptr_b];

    // FIFO A control; per-entry valid bits feed the pending scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_a <= '0;
            rd_ptr_a <= '0;
            count_a  <= '0;
            vld_a    <= '0;
        end else begin
            if (pop_a) begin
                rd_ptr_a        <= rd_ptr_a + 1'b1;
                vld_a[rd_ptr_a] <= 1'b0;
            end
            if (push_a) begin
                wr_ptr_a        <= wr_ptr_a + 1'b1;
                vld_a[wr_ptr_a] <= 1'b1;
            end
            case ({push_a, pop_a})
                2'b10:   count_a <= count_a + 1'b1;
                2'b01:   count_a <= count_a - 1'b1;
                default: count_a <= count_a;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_a) begin
            addr_a[wr_ptr_a] <= bus.a_addr;
            data_a[wr_ptr_a] <= bus.a_data;
        end
    end

    // FIFO B control.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_b <= '0;
            rd_ptr_b <= '0;
            count_b  <= '0;
            vld_b    <= '0;
        end else begin
            if (pop_b) begin
                rd_ptr_b        <= rd_ptr_b + 1'b1;
                vld_b[rd_ptr_b] <= 1'b0;
            end
            if (push_b) begin
                wr_ptr_b        <= wr_ptr_b + 1'b1;
                vld_b[wr_ptr_b] <= 1'b1;
            end
            case ({push_b, pop_b})
                2'b10:   count_b <= count_b + 1'b1;
                2'b01:   count_b <= count_b - 1'b1;
                default: count_b <= count_b;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_b) begin
            addr_b[wr_ptr_b] <= bus.b_addr;
            data_b[wr_ptr_b] <= bus.b_data;
        end
    end

    // Write port. An r0 head is consumed without a write since r0 is hardwired
    // zero; wa3/wd3 keep their last values whenever no write issues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we3_q <= 1'b0;
            wa3_q <= '0;
            wd3_q <= '0;
        end else if ((pop_a || pop_b) && (head_addr != '0)) begin
            we3_q <= 1'b1;
            wa3_q <= head_addr;
            wd3_q <= head_data;
        end else begin
            we3_q <= 1'b0;
        end
    end

    always_comb begin
        pend = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (vld_a[j]) pend[addr_a[j]] = 1'b1;
            if (vld_b[j]) pend[addr_b[j]] = 1'b1;
        end
        if (we3_q) pend[wa3_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign bus.we3     = we3_q;
    assign bus.wa3     = wa3_q;
    assign bus.wd3     = wd3_q;
    assign bus.pending = reset ? pend : '0;
    assign bus.busy    = reset && (nonempty_a || nonempty_b || we3_q);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    regfile_write_arbiter_if #(.AW(3), .DW(8)) bus ();

    regfile_write_arbiter #(.DEPTH(2), .AW(3), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] ad, input logic [7:0] d);
        bus.a_valid = v;
        bus.a_addr  = ad;
        bus.a_data  = d;
    endtask

    task automatic drive_b(input logic v, input logic [2:0] ad, input logic [7:0] d);
        bus.b_valid = v;
        bus.b_addr  = ad;
        bus.b_data  = d;
    endtask

    // Reset pulse: falls 3 time units after an edge, rises mid-cycle next period.
    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic chk_port(input string tag, input logic [2:0] wa, input logic [7:0] wd);
        chk(tag, {20'd0, bus.we3, bus.wa3, bus.wd3}, {20'd0, 1'b1, wa, wd});
    endtask

    logic [10:0] cap[$];
    logic [10:0] exp_w;
    logic [10:0] obs_w;
    logic        acc_a, acc_b;
    int          ia, ib;

    initial begin
        reset = 1'b0;
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b0, 3'd0, 8'h00);

        // Reset state
        #2;
        chk("rst_a_ready", bus.a_ready, 0);
        chk("rst_b_ready", bus.b_ready, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_busy",    bus.busy,    0);
        chk("rst_we3",     bus.we3,     0);
        chk("rst_wa3",     bus.wa3,     0);
        chk("rst_wd3",     bus.wd3,     0);
        @(posedge clk);
        #3 reset = 1'b1;

        // 1: single write, latency and pending window
        drive_a(1'b1, 3'd3, 8'h5A);
        step();
        drive_a(1'b0, 3'd0, 8'h00);
        chk("t1_we3_e1",     bus.we3,     0);
        chk("t1_pending_e1", bus.pending, 32'h08);
        chk("t1_busy_e1",    bus.busy,    1);
        step();
        chk_port("t1_port_e2", 3'd3, 8'h5A);
        chk("t1_pending_e2", bus.pending, 32'h08);
        step();
        chk("t1_we3_e3",     bus.we3,     0);
        chk("t1_pending_e3", bus.pending, 0);
        chk("t1_busy_e3",    bus.busy,    0);

        // 2: simultaneous push, A first after reset
        do_reset();
        drive_a(1'b1, 3'd1, 8'h11);
        drive_b(1'b1, 3'd2, 8'h22);
        step();
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b0, 3'd0, 8'h00);
        chk("t2_pending_e1", bus.pending, 32'h06);
        step();
        chk_port("t2_port_first", 3'd1, 8'h11);
        step();
        chk_port("t2_port_second", 3'd2, 8'h22);
        step();
        chk("t2_we3_idle", bus.we3, 0);

        // 3: contention, strict alternation and per-source order
        ia = 0;
        ib = 0;
        for (int c = 0; c < 16; c++) begin
            drive_a(ia < 6, 3'd4, 8'(8'hA0 + ia));
            drive_b(ib < 6, 3'd5, 8'(8'hB0 + ib));
            acc_a = bus.a_valid && bus.a_ready;
            acc_b = bus.b_valid && bus.b_ready;
            step();
            if (acc_a) ia++;
            if (acc_b) ib++;
            if (bus.we3) cap.push_back({bus.wa3, bus.wd3});
        end
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b0, 3'd0, 8'h00);
        chk("t3_write_count", cap.size(), 12);
        for (int k = 0; k < 12; k++) begin
            exp_w = (k % 2 == 0) ? {3'd4, 8'(8'hA0 + k / 2)} : {3'd5, 8'(8'hB0 + k / 2)};
            obs_w = (k < cap.size()) ? cap[k] : 11'h7FF;
            chk($sformatf("t3_write%0d", k), obs_w, exp_w);
        end
        chk("t3_busy_end", bus.busy, 0);

        // 4: A fills while B competes; no loss or duplication
        drive_a(1'b1, 3'd6, 8'h60);
        drive_b(1'b1, 3'd7, 8'h71);
        step();
        drive_a(1'b1, 3'd6, 8'h61);
        drive_b(1'b1, 3'd7, 8'h72);
        step();
        chk_port("t4_port_60", 3'd6, 8'h60);
        drive_a(1'b1, 3'd6, 8'h62);
        drive_b(1'b0, 3'd0, 8'h00);
        step();
        chk_port("t4_port_71", 3'd7, 8'h71);
        drive_a(1'b1, 3'd6, 8'h63);
        chk("t4_a_ready_full", bus.a_ready, 0);
        step();
        chk_port("t4_port_61", 3'd6, 8'h61);
        chk("t4_a_ready_room", bus.a_ready, 1);
        step();
        drive_a(1'b0, 3'd0, 8'h00);
        chk_port("t4_port_72", 3'd7, 8'h72);
        step();
        chk_port("t4_port_62", 3'd6, 8'h62);
        step();
        chk_port("t4_port_63", 3'd6, 8'h63);
        step();
        chk("t4_we3_idle", bus.we3,  0);
        chk("t4_busy_end", bus.busy, 0);

        // 5: write to r0 is consumed silently
        drive_b(1'b1, 3'd0, 8'h77);
        chk("t5_b_ready", bus.b_ready, 1);
        step();
        drive_b(1'b0, 3'd0, 8'h00);
        chk("t5_busy_queued", bus.busy,    1);
        chk("t5_pending_e1",  bus.pending, 0);
        chk("t5_we3_e1",      bus.we3,     0);
        step();
        chk("t5_we3_e2",  bus.we3,  0);
        chk("t5_busy_e2", bus.busy, 0);

        // 6: reset mid-operation discards queued writes
        drive_a(1'b1, 3'd1, 8'h31);
        drive_b(1'b1, 3'd2, 8'h41);
        step();
        drive_a(1'b1, 3'd3, 8'h32);
        drive_b(1'b1, 3'd4, 8'h42);
        step();
        drive_a(1'b0, 3'd0, 8'h00);
        drive_b(1'b0, 3'd0, 8'h00);
        chk_port("t6_port_31", 3'd1, 8'h31);
        chk("t6_pending_pre", bus.pending, 32'h1E);
        #2 reset = 1'b0;
        #1;
        chk("t6_we3_rst",     bus.we3,     0);
        chk("t6_pending_rst", bus.pending, 0);
        chk("t6_busy_rst",    bus.busy,    0);
        chk("t6_a_ready_rst", bus.a_ready, 0);
        chk("t6_b_ready_rst", bus.b_ready, 0);
        chk("t6_wa3_rst",     bus.wa3,     0);
        chk("t6_wd3_rst",     bus.wd3,     0);
        #10 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("t6_we3_after%0d", c), bus.we3, 0);
        end
        chk("t6_busy_after",    bus.busy,    0);
        chk("t6_pending_after", bus.pending, 0);
        chk("t6_a_ready_after", bus.a_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
